pc_fetch_unit: RTL



---
 rtl/pc_fetch_unit_if.sv | 31 +++
 rtl/pc_fetch_unit.sv | 104 ++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall requests from the core and the fetch-side
// outputs towards instruction memory and the link-register writeback path.
interface pc_fetch_unit_if;
    logic        stall;
    logic        halt_req;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_en;
    logic [31:0] jump_target;
    logic [31:0] instr_address;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        misalign_fault;
    logic        bound_fault;
    logic        halted;
    logic [31:0] fetch_count;

    // Fetch unit side
    modport master (
        input  stall, halt_req, branch_taken, branch_target, jump_en, jump_target,
        output instr_address, pc_plus4, fetch_valid, misalign_fault, bound_fault,
               halted, fetch_count
    );

    // Core / instruction-memory side
    modport slave (
        output stall, halt_req, branch_taken, branch_target, jump_en, jump_target,
        input  instr_address, pc_plus4, fetch_valid, misalign_fault, bound_fault,
               halted, fetch_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: next-PC selection (sequential, branch,
// jump), stall/halt handling, target checking with sticky faults, and a
// saturating count of PC advances.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS   = 33
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        misalign_q;
    logic        bound_q;
    logic        fetch_valid_q;
    logic        halted_q;

    logic [31:0] cand;
    logic        cand_misalign;
    logic        cand_oob;

    // Next-PC candidate by redirect priority, plus its alignment/range checks
    always_comb begin
        cand = pc_q + 32'd4;
        if (bus.jump_en) begin
            cand = bus.jump_target & ~32'd1;
        end else if (bus.branch_taken) begin
            cand = bus.branch_target;
        end
        cand_misalign = (cand[1:0] != 2'b00);
        cand_oob      = (cand[31:2] >= IMEM_LIMIT);
        count_d       = (count_q == '1) ? count_q : count_q + 32'd1;
    end

    // Fetch FSM with registered status outputs; halt beats stall beats redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            count_q       <= '0;
            misalign_q    <= 1'b0;
            bound_q       <= 1'b0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q       <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                RUN: begin
                    if (bus.halt_req) begin
                        state_q       <= HALT;
                        fetch_valid_q <= 1'b0;
                        halted_q      <= 1'b1;
                    end else if (!bus.stall) begin
                        if (cand_misalign) begin
                            misalign_q    <= 1'b1;
                            state_q       <= FAULT;
                            fetch_valid_q <= 1'b0;
                        end else if (cand_oob) begin
                            bound_q       <= 1'b1;
                            state_q       <= FAULT;
                            fetch_valid_q <= 1'b0;
                        end else begin
                            pc_q    <= cand;
                            count_q <= count_d;
                        end
                    end
                end
                HALT, FAULT: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q       <= BOOT;
                    fetch_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_address  = pc_q;
    assign bus.pc_plus4       = pc_q + 32'd4;
    assign bus.fetch_valid    = fetch_valid_q;
    assign bus.misalign_fault = misalign_q;
    assign bus.bound_fault    = bound_q;
    assign bus.halted         = halted_q;
    assign bus.fetch_count    = count_q;

endmodule
